float16_to_fixed: RTL and testbench
===================================

FLOAT16_TO_FIXED -- requirements
Module: float16_to_fixed

Interface
REQ-001 The block SHALL be a single-clock design with a synchronous, active-high reset; parameters are none, and the Q format is fixed at Q16.16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_data  input  16  IEEE-754 half-precision operand (sign[15], exp[14:10], frac[9:0]).
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_ready  output  1  block can accept an operand this cycle.
REQ-007 out_data  output  32  signed two's-complement Q16.16 result.
REQ-008 out_valid  output  1  out_data and flags are valid.
REQ-009 out_ready  input  1  consumer accepts the result this cycle.
REQ-010 out_overflow  output  1  the magnitude exceeded the Q16.16 range, or the operand was infinity.
REQ-011 out_inexact  output  1  nonzero bits were discarded by a right shift.
REQ-012 out_invalid  output  1  the operand was NaN.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT, OUT. in_ready is 1 only in IDLE.
REQ-014 An operand SHALL be accepted on a clock edge where in_valid and in_ready are both 1; in_data is ignored at all other times.
REQ-015 On acceptance, the block SHALL compute sig = {exp!=0, frac}, e_eff = max(exp,1), and shift = e_eff-9, giving a range of -8..+21.
REQ-016 Special operands SHALL go directly to OUT: zero (exp=0, frac=0) gives 0; NaN gives 0 with invalid=1; +Inf gives 0x7FFFFFFF with overflow=1; -Inf gives 0x80000000 with overflow=1.
REQ-017 For finite nonzero operands, the block SHALL load a 32-bit magnitude register with sig, load a count with |shift|, and enter SHIFT.
REQ-018 In SHIFT, each cycle with count>0 SHALL shift the magnitude one bit (left if shift>0, right otherwise) and decrement count; a 1 shifted out on a right shift SHALL set the sticky inexact flag.
REQ-019 In SHIFT with count=0, the block SHALL apply the sign (two's-complement negate when sign=1), evaluate overflow, register the outputs, and enter OUT.
REQ-020 Overflow SHALL be defined as: magnitude > 0x7FFFFFFF with sign=0, or magnitude > 0x80000000 with sign=1.
REQ-021 Right shifts SHALL truncate the magnitude toward zero before negation.
REQ-022 Latency from the acceptance edge to out_valid SHALL be 1 cycle for special operands and |shift|+2 cycles for finite nonzero operands.
REQ-023 In OUT, out_valid SHALL be 1 and out_data plus flags SHALL be held stable until out_ready=1.
REQ-024 When out_ready=1 in OUT, the FSM SHALL return to IDLE; in_ready rises the following cycle and there is no same-cycle bypass.
REQ-025 out_ready asserted outside OUT SHALL have no effect.

Reset
REQ-026 On rst=1, the FSM SHALL go to IDLE; out_data, count, and the magnitude register SHALL be 0; out_valid and all flags SHALL be 0; in_ready SHALL be 1 in the cycle after reset.
REQ-027 Reset asserted during SHIFT or OUT SHALL discard the in-flight operand with no output handshake.

Configuration
REQ-028 When FLOAT16_TO_FIXED_SATURATE_EN is defined, a finite overflow SHALL produce 0x7FFFFFFF (positive) or 0x80000000 (negative).
REQ-029 When the macro is undefined, a finite overflow SHALL produce the low 32 bits of the two's-complement result (wrap).
REQ-030 out_overflow SHALL be set on overflow in both builds; Inf and NaN handling SHALL be unaffected by the macro.

Structure
REQ-031 A shared package float16_pkg SHALL hold the field widths (SIGN=1, EXP=5, FRAC=10), EXP_BIAS=15, FIX_FRAC_BITS=16, the FSM state encoding, and the fixed-point saturation constants.
REQ-032 A combinational sub-module float16_unpack SHALL extract sign, exp, sig, and shift, and classify the operand as zero, subnormal, normal, infinity, or NaN.

Verification
REQ-033 Input 0x3C00 (1.0) -> out_data=0x00010000, all flags 0, out_valid 8 cycles after acceptance.
REQ-034 Input 0xC100 (-2.5) -> out_data=0xFFFD8000, flags 0, latency 9 cycles.
REQ-035 Input 0x0001 (smallest subnormal) -> out_data=0, inexact=1, latency 10 cycles.
REQ-036 Input 0x7BFF (65504) -> overflow=1; out_data=0x7FFFFFFF with the macro defined, 0xFFE00000 without it.
REQ-037 Inputs 0x7E00 (NaN) and 0xFC00 (-Inf) -> out_data 0 with invalid=1, then 0x80000000 with overflow=1, each with latency 1; hold out_ready=0 for 5 cycles and check outputs stay stable and in_ready=0.
REQ-038 Assert rst during SHIFT for 0x3C00 -> no out_valid; the next operand 0x4000 (2.0) -> 0x00020000.

Source files
------------

// File: rtl/float16_pkg.sv
// Shared constants, FSM encoding and helpers for the half-precision to Q16.16 converter.
package float16_pkg;

   localparam int unsigned SIGN_BITS     = 1;
   localparam int unsigned EXP_BITS      = 5;
   localparam int unsigned FRAC_BITS     = 10;
   localparam int unsigned EXP_BIAS      = 15;
   localparam int unsigned FIX_FRAC_BITS = 16;
   localparam int unsigned FIX_BITS      = 32;
   localparam int unsigned SIG_BITS      = FRAC_BITS + 1;
   localparam int unsigned SHIFT_BITS    = 6;
   localparam int unsigned COUNT_BITS    = 5;

   // Exponent at which sig (binary point after bit FRAC_BITS) lines up with Q16.16 unshifted.
   localparam int unsigned SHIFT_BIAS = EXP_BIAS + FRAC_BITS - FIX_FRAC_BITS;

   localparam logic [FIX_BITS-1:0] FIX_MAX = 32'h7FFF_FFFF;
   localparam logic [FIX_BITS-1:0] FIX_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StOut
   } state_e;

   function automatic logic [COUNT_BITS-1:0] shift_count(input logic [SHIFT_BITS-1:0] shift);
      logic [SHIFT_BITS-1:0] neg;
      neg = ~shift + 1'b1;
      return shift[SHIFT_BITS-1] ? neg[COUNT_BITS-1:0] : shift[COUNT_BITS-1:0];
   endfunction

endpackage

// File: rtl/float16_unpack.sv
// Combinational field extraction and classification of a half-precision operand.
module float16_unpack
   import float16_pkg::*;
(
   input  logic [15:0] in_data,
   output logic        sign,
   output logic [10:0] sig,
   output logic [5:0]  shift,
   output logic        is_zero,
   output logic        is_subnormal,
   output logic        is_normal,
   output logic        is_inf,
   output logic        is_nan
);

   logic [EXP_BITS-1:0]  exp;
   logic [FRAC_BITS-1:0] frac;
   logic [EXP_BITS-1:0]  e_eff;
   logic                 exp_nz;
   logic                 exp_max;
   logic                 frac_nz;

   always_comb begin
      sign    = in_data[FRAC_BITS+EXP_BITS +: SIGN_BITS];
      exp     = in_data[FRAC_BITS +: EXP_BITS];
      frac    = in_data[FRAC_BITS-1:0];
      exp_nz  = |exp;
      exp_max = &exp;
      frac_nz = |frac;
      sig     = {exp_nz, frac};
      // Subnormals share the exponent of the smallest normal.
      e_eff   = exp_nz ? exp : EXP_BITS'(1);
      shift   = {1'b0, e_eff} - SHIFT_BITS'(SHIFT_BIAS);

      is_zero      = !exp_nz && !frac_nz;
      is_subnormal = !exp_nz && frac_nz;
      is_normal    = exp_nz && !exp_max;
      is_inf       = exp_max && !frac_nz;
      is_nan       = exp_max && frac_nz;
   end

endmodule

// File: rtl/float16_to_fixed.sv
// Serial half-precision to signed Q16.16 converter, one shift step per cycle.
// Define FLOAT16_TO_FIXED_SATURATE_EN to clamp finite overflows instead of wrapping.
module float16_to_fixed
   import float16_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_overflow,
   output logic        out_inexact,
   output logic        out_invalid
);

   state_e state_q, state_d;

   logic [FIX_BITS-1:0]   mag_q, mag_d;
   logic [COUNT_BITS-1:0] count_q, count_d;
   logic                  left_q, left_d;
   logic                  sign_q, sign_d;
   logic                  sticky_q, sticky_d;
   logic [FIX_BITS-1:0]   out_data_q, out_data_d;
   logic                  overflow_q, overflow_d;
   logic                  inexact_q, inexact_d;
   logic                  invalid_q, invalid_d;

   logic                  u_sign;
   logic [SIG_BITS-1:0]   u_sig;
   logic [SHIFT_BITS-1:0] u_shift;
   logic                  u_zero;
   logic                  u_subnormal;
   logic                  u_normal;
   logic                  u_inf;
   logic                  u_nan;

   logic [FIX_BITS-1:0]   neg_mag;
   logic [FIX_BITS-1:0]   result;
   logic                  ovf;

   float16_unpack u_unpack (
      .in_data      (in_data),
      .sign         (u_sign),
      .sig          (u_sig),
      .shift        (u_shift),
      .is_zero      (u_zero),
      .is_subnormal (u_subnormal),
      .is_normal    (u_normal),
      .is_inf       (u_inf),
      .is_nan       (u_nan)
   );

   always_comb begin
      neg_mag = ~mag_q + 1'b1;
      ovf     = sign_q ? (mag_q > FIX_MIN) : (mag_q > FIX_MAX);
`ifdef FLOAT16_TO_FIXED_SATURATE_EN
      if (ovf) begin
         result = sign_q ? FIX_MIN : FIX_MAX;
      end else begin
         result = sign_q ? neg_mag : mag_q;
      end
`else
      result = sign_q ? neg_mag : mag_q;
`endif
   end

   always_comb begin
      state_d    = state_q;
      mag_d      = mag_q;
      count_d    = count_q;
      left_d     = left_q;
      sign_d     = sign_q;
      sticky_d   = sticky_q;
      out_data_d = out_data_q;
      overflow_d = overflow_q;
      inexact_d  = inexact_q;
      invalid_d  = invalid_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               sign_d     = u_sign;
               sticky_d   = 1'b0;
               mag_d      = {{(FIX_BITS-SIG_BITS){1'b0}}, u_sig};
               count_d    = shift_count(u_shift);
               left_d     = !u_shift[SHIFT_BITS-1] && (u_shift != '0);
               out_data_d = '0;
               overflow_d = 1'b0;
               inexact_d  = 1'b0;
               invalid_d  = 1'b0;
               unique case (1'b1)
                  u_zero: begin
                     state_d = StOut;
                  end
                  u_nan: begin
                     invalid_d = 1'b1;
                     state_d   = StOut;
                  end
                  u_inf: begin
                     out_data_d = u_sign ? FIX_MIN : FIX_MAX;
                     overflow_d = 1'b1;
                     state_d    = StOut;
                  end
                  u_subnormal, u_normal: begin
                     state_d = StShift;
                  end
                  default: begin
                     state_d = StIdle;
                  end
               endcase
            end
         end
         StShift: begin
            if (count_q != '0) begin
               if (left_q) begin
                  mag_d = {mag_q[FIX_BITS-2:0], 1'b0};
               end else begin
                  mag_d = {1'b0, mag_q[FIX_BITS-1:1]};
                  if (mag_q[0]) begin
                     sticky_d = 1'b1;
                  end
               end
               count_d = count_q - 1'b1;
            end else begin
               out_data_d = result;
               overflow_d = ovf;
               inexact_d  = sticky_q;
               invalid_d  = 1'b0;
               state_d    = StOut;
            end
         end
         StOut: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         mag_q      <= '0;
         count_q    <= '0;
         left_q     <= 1'b0;
         sign_q     <= 1'b0;
         sticky_q   <= 1'b0;
         out_data_q <= '0;
         overflow_q <= 1'b0;
         inexact_q  <= 1'b0;
         invalid_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         mag_q      <= mag_d;
         count_q    <= count_d;
         left_q     <= left_d;
         sign_q     <= sign_d;
         sticky_q   <= sticky_d;
         out_data_q <= out_data_d;
         overflow_q <= overflow_d;
         inexact_q  <= inexact_d;
         invalid_q  <= invalid_d;
      end
   end

   assign in_ready     = (state_q == StIdle);
   assign out_valid    = (state_q == StOut);
   assign out_data     = out_data_q;
   assign out_overflow = overflow_q;
   assign out_inexact  = inexact_q;
   assign out_invalid  = invalid_q;

endmodule

// File: tb/tb_float16_to_fixed.sv
// Directed self-checking bench for float16_to_fixed; expected overflow data follows
// FLOAT16_TO_FIXED_SATURATE_EN when it is defined.
module tb_float16_to_fixed;

   logic        clk;
   logic        rst;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_overflow;
   logic        out_inexact;
   logic        out_invalid;

   int checks = 0;
   int errors = 0;

   float16_to_fixed dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_overflow (out_overflow),
      .out_inexact  (out_inexact),
      .out_invalid  (out_invalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one operand for one edge, once the block is ready; returns #1 after acceptance.
   task automatic send(input logic [15:0] data);
      int guard;
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      in_data  = data;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Latency counted so an operand landing in OUT on its acceptance edge reads 1.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 16'h0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
      end
      checks++;
      if (out_data !== 32'h0 || out_overflow !== 1'b0 || out_inexact !== 1'b0 ||
          out_invalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: data=%h ovf=%b inx=%b inv=%b, required all zero",
                  out_data, out_overflow, out_inexact, out_invalid);
      end
   endtask

   task automatic test_finite();
      logic [15:0] vin [7] = '{16'h3C00, 16'hC100, 16'h0001, 16'h2001, 16'hA001, 16'hF800,
                               16'h2400};
      logic [31:0] vexp [7] = '{32'h0001_0000, 32'hFFFD_8000, 32'h0, 32'h0000_0200,
                                32'hFFFF_FE00, 32'h8000_0000, 32'h0000_0400};
      logic        vinx [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      int          vlat [7] = '{8, 9, 10, 3, 3, 23, 2};
      int          lat;
      for (int i = 0; i < 7; i++) begin
         send(vin[i]);
         wait_valid(lat);
         checks++;
         if (lat !== vlat[i]) begin
            errors++;
            $display("FAIL finite_latency[%h]: got %0d, required %0d", vin[i], lat, vlat[i]);
         end
         checks++;
         if (out_data !== vexp[i] || out_inexact !== vinx[i] || out_overflow !== 1'b0 ||
             out_invalid !== 1'b0) begin
            errors++;
            $display("FAIL finite_result[%h]: data=%h inx=%b ovf=%b inv=%b, required %h %b 0 0",
                     vin[i], out_data, out_inexact, out_overflow, out_invalid, vexp[i], vinx[i]);
         end
         consume();
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL finite_release[%h]: in_ready=%b out_valid=%b, required 1 0",
                     vin[i], in_ready, out_valid);
         end
      end
   endtask

   task automatic test_overflow();
      logic [15:0] vin [3] = '{16'h7BFF, 16'hFBFF, 16'h7800};
`ifdef FLOAT16_TO_FIXED_SATURATE_EN
      logic [31:0] vexp [3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
`else
      logic [31:0] vexp [3] = '{32'hFFE0_0000, 32'h0020_0000, 32'h8000_0000};
`endif
      int lat;
      for (int i = 0; i < 3; i++) begin
         send(vin[i]);
         wait_valid(lat);
         checks++;
         if (lat !== 23 || out_data !== vexp[i] || out_overflow !== 1'b1 ||
             out_inexact !== 1'b0 || out_invalid !== 1'b0) begin
            errors++;
            $display("FAIL overflow[%h]: lat=%0d data=%h ovf=%b inx=%b inv=%b, required 23 %h 1 0 0",
                     vin[i], lat, out_data, out_overflow, out_inexact, out_invalid, vexp[i]);
         end
         consume();
      end
   endtask

   task automatic test_specials();
      logic [15:0] vin [4] = '{16'h7E00, 16'hFC00, 16'h0000, 16'h7C00};
      logic [31:0] vexp [4] = '{32'h0, 32'h8000_0000, 32'h0, 32'h7FFF_FFFF};
      logic        vovf [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic        vinv [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      int          lat;
      for (int i = 0; i < 4; i++) begin
         send(vin[i]);
         wait_valid(lat);
         checks++;
         if (lat !== 1 || out_data !== vexp[i] || out_overflow !== vovf[i] ||
             out_invalid !== vinv[i] || out_inexact !== 1'b0) begin
            errors++;
            $display("FAIL special[%h]: lat=%0d data=%h ovf=%b inv=%b inx=%b, required 1 %h %b %b 0",
                     vin[i], lat, out_data, out_overflow, out_invalid, out_inexact, vexp[i],
                     vovf[i], vinv[i]);
         end
         for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== vexp[i] ||
                out_overflow !== vovf[i] || out_invalid !== vinv[i]) begin
               errors++;
               $display("FAIL special_hold[%h] cycle %0d: valid=%b ready=%b data=%h ovf=%b inv=%b",
                        vin[i], c, out_valid, in_ready, out_data, out_overflow, out_invalid);
            end
         end
         consume();
      end
   endtask

   // Junk on in_data while busy must be ignored; out_ready held high before OUT is harmless.
   task automatic test_back_to_back();
      int lat;
      send(16'hC100);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'h7C00;
      wait_valid(lat);
      in_valid = 1'b0;
      checks++;
      if (lat !== 9 || out_data !== 32'hFFFD_8000 || out_overflow !== 1'b0) begin
         errors++;
         $display("FAIL busy_ignore: lat=%0d data=%h ovf=%b, required 9 fffd8000 0",
                  lat, out_data, out_overflow);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL early_ready_release: valid=%b ready=%b, required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_midflight();
      int lat;
      logic seen;
      send(16'h3C00);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (out_valid) seen = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (seen !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midflight_discard: saw_valid=%b in_ready=%b, required 0 1", seen, in_ready);
      end
      send(16'h4000);
      wait_valid(lat);
      checks++;
      if (lat !== 9 || out_data !== 32'h0002_0000 || out_inexact !== 1'b0 ||
          out_overflow !== 1'b0) begin
         errors++;
         $display("FAIL after_reset: lat=%0d data=%h, required 9 00020000", lat, out_data);
      end
      consume();
   endtask

   initial begin
      test_reset();
      test_finite();
      test_overflow();
      test_specials();
      test_back_to_back();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
